// File: rtl/ysyx_22050019_axi_rd_arbiter.sv
// Two-master (IFU/LSU) to one-slave AXI-lite read arbiter, one outstanding read.
// LSU has fixed priority; a consecutive-win counter forces IFU through after STARVE_LIMIT LSU wins.
module ysyx_22050019_axi_rd_arbiter_port #(
  parameter int DATA_W = 64
) (
  input  logic              sel,
  input  logic              ar_ph,
  input  logic              r_ph,
  input  logic              s_arready,
  input  logic              s_rvalid,
  input  logic [DATA_W-1:0] s_rdata,
  output logic              arready,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata
);
  assign arready = sel && ar_ph && s_arready;
  assign rvalid  = sel && r_ph && s_rvalid;
  assign rdata   = (sel && r_ph) ? s_rdata : '0;
endmodule

module ysyx_22050019_axi_rd_arbiter #(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ifu_arvalid,
  input  logic [ADDR_W-1:0] ifu_araddr,
  output logic              ifu_arready,
  output logic              ifu_rvalid,
  output logic [DATA_W-1:0] ifu_rdata,
  input  logic              ifu_rready,
  input  logic              lsu_arvalid,
  input  logic [ADDR_W-1:0] lsu_araddr,
  output logic              lsu_arready,
  output logic              lsu_rvalid,
  output logic [DATA_W-1:0] lsu_rdata,
  input  logic              lsu_rready,
  output logic              s_arvalid,
  output logic [ADDR_W-1:0] s_araddr,
  input  logic              s_arready,
  input  logic              s_rvalid,
  input  logic [DATA_W-1:0] s_rdata,
  output logic              s_rready
);
  localparam int         NUM_M = 2;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, AR, R} state_t;

  state_t     state, state_nxt;
  logic       grant, grant_nxt;
  logic [3:0] starve_cnt, starve_cnt_nxt;

  // Master index matches grant encoding: 0 = IFU, 1 = LSU.
  logic [NUM_M-1:0]             rready, sel, arready, rvalid;
  logic [NUM_M-1:0][ADDR_W-1:0] araddr;
  logic [NUM_M-1:0][DATA_W-1:0] rdata;

  assign rready = {lsu_rready, ifu_rready};
  assign araddr = {lsu_araddr, ifu_araddr};
  assign sel    = {grant, !grant};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= 1'b0;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      starve_cnt <= starve_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    starve_cnt_nxt = starve_cnt;
    s_arvalid      = 1'b0;
    s_araddr       = '0;
    s_rready       = 1'b0;
    case (state)
      IDLE: begin
        if (ifu_arvalid || lsu_arvalid) begin
          state_nxt = AR;
          grant_nxt = lsu_arvalid && !(ifu_arvalid && starve_cnt == LIMIT);
          // Counter only tracks LSU wins taken while IFU was waiting.
          if (!grant_nxt)
            starve_cnt_nxt = '0;
          else if (ifu_arvalid && starve_cnt != 4'hf)
            starve_cnt_nxt = starve_cnt + 4'd1;
        end
      end
      AR: begin
        s_arvalid = 1'b1;
        s_araddr  = araddr[grant];
        if (s_arready) state_nxt = R;
      end
      R: begin
        s_rready = rready[grant];
        if (s_rvalid && s_rready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  for (genvar m = 0; m < NUM_M; m++) begin : g_port
    ysyx_22050019_axi_rd_arbiter_port #(.DATA_W(DATA_W)) u_port (
      .sel       (sel[m]),
      .ar_ph     (state == AR),
      .r_ph      (state == R),
      .s_arready (s_arready),
      .s_rvalid  (s_rvalid),
      .s_rdata   (s_rdata),
      .arready   (arready[m]),
      .rvalid    (rvalid[m]),
      .rdata     (rdata[m])
    );
  end

  assign ifu_arready = arready[0];
  assign ifu_rvalid  = rvalid[0];
  assign ifu_rdata   = rdata[0];
  assign lsu_arready = arready[1];
  assign lsu_rvalid  = rvalid[1];
  assign lsu_rdata   = rdata[1];
endmodule

// File: tb/tb_ysyx_22050019_axi_rd_arbiter.sv
// Directed + random bench for the IFU/LSU read arbiter against a transaction-level grant model.
module tb_ysyx_22050019_axi_rd_arbiter;
  localparam int AW  = 64;
  localparam int DW  = 64;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ifu_arvalid = 1'b0, ifu_rready = 1'b0;
  logic [AW-1:0] ifu_araddr = '0;
  logic          ifu_arready, ifu_rvalid;
  logic [DW-1:0] ifu_rdata;
  logic          lsu_arvalid = 1'b0, lsu_rready = 1'b0;
  logic [AW-1:0] lsu_araddr = '0;
  logic          lsu_arready, lsu_rvalid;
  logic [DW-1:0] lsu_rdata;
  logic          s_arvalid, s_rready;
  logic [AW-1:0] s_araddr;
  logic          s_arready = 1'b0, s_rvalid = 1'b0;
  logic [DW-1:0] s_rdata = '0;

  always #5 clk = ~clk;

  ysyx_22050019_axi_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_arvalid(ifu_arvalid), .ifu_araddr(ifu_araddr), .ifu_arready(ifu_arready),
    .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata), .ifu_rready(ifu_rready),
    .lsu_arvalid(lsu_arvalid), .lsu_araddr(lsu_araddr), .lsu_arready(lsu_arready),
    .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata), .lsu_rready(lsu_rready),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arready(s_arready),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rready(s_rready)
  );

  int total = 0;
  int bad   = 0;
  int m_cnt = 0;   // model: LSU wins in a row while IFU waited
  int w;
  bit obs_g[$];    // winner observed at each AR handshake (1 = LSU)

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk(tag, 64'({s_arvalid, s_rready, ifu_arready, lsu_arready, ifu_rvalid, lsu_rvalid,
                  |s_araddr, |ifu_rdata, |lsu_rdata}), 64'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Winner from the pending requests: lone requester wins, else LSU unless IFU waited LIM times.
  task automatic model_grant(output int win);
    if (ifu_arvalid && lsu_arvalid) win = (m_cnt == LIM) ? 0 : 1;
    else                            win = lsu_arvalid ? 1 : 0;
    if (win == 0)         m_cnt = 0;
    else if (ifu_arvalid) m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
  endtask

  // Called at a negedge in IDLE with requests already driven; returns at the following IDLE negedge.
  task automatic txn(input int arw, input int rw, input int rrw, input logic [DW-1:0] data);
    int win;
    logic [AW-1:0] exp_a;
    model_grant(win);
    exp_a = win ? lsu_araddr : ifu_araddr;
    tick();
    repeat (arw) begin
      #1;
      chk("ar_hold_valid", 64'(s_arvalid), 64'd1);
      chk("ar_hold_addr", s_araddr, exp_a);
      chk("ar_hold_rdy", 64'({ifu_arready, lsu_arready}), 64'd0);
      tick();
    end
    s_arready = 1'b1;
    #1;
    chk("ar_valid", 64'(s_arvalid), 64'd1);
    chk("ar_addr", s_araddr, exp_a);
    chk("ar_grant", 64'({lsu_arready, ifu_arready}), win ? 64'd2 : 64'd1);
    obs_g.push_back(lsu_arready);
    tick();
    s_arready = 1'b0;
    if (win != 0) lsu_arvalid = 1'b0; else ifu_arvalid = 1'b0;
    repeat (rw) begin
      #1 chk("r_wait", 64'({s_arvalid, ifu_rvalid, lsu_rvalid}), 64'd0);
      tick();
    end
    s_rvalid = 1'b1;
    s_rdata  = data;
    repeat (rrw) begin
      #1;
      chk("r_stall_valid", 64'({lsu_rvalid, ifu_rvalid}), win ? 64'd2 : 64'd1);
      chk("r_stall_data", win ? lsu_rdata : ifu_rdata, data);
      chk("r_stall_rready", 64'(s_rready), 64'd0);
      tick();
    end
    if (win != 0) lsu_rready = 1'b1; else ifu_rready = 1'b1;
    #1;
    chk("r_valid", 64'({lsu_rvalid, ifu_rvalid}), win ? 64'd2 : 64'd1);
    chk("r_data", win ? lsu_rdata : ifu_rdata, data);
    chk("r_other_data", win ? ifu_rdata : lsu_rdata, 64'd0);
    chk("r_rready", 64'(s_rready), 64'd1);
    tick();
    s_rvalid   = 1'b0;
    s_rdata    = '0;
    ifu_rready = 1'b0;
    lsu_rready = 1'b0;
    #1 chk_idle("post_r_idle");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] seq;
    #2 chk_idle("in_reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk_idle("after_reset");

    // IFU-only read
    ifu_arvalid = 1'b1;
    ifu_araddr  = 64'h8000_0000;
    txn(0, 0, 0, 64'h0000_0413);
    chk("ifu_only_winner", 64'(obs_g[$]), 64'd0);

    // Simultaneous: LSU first, IFU after one IDLE cycle
    ifu_arvalid = 1'b1; ifu_araddr = 64'h8000_0004;
    lsu_arvalid = 1'b1; lsu_araddr = 64'h8000_1000;
    txn(0, 0, 0, 64'h1111_2222_3333_4444);
    chk("simul_first_lsu", 64'(obs_g[$]), 64'd1);
    txn(0, 0, 0, 64'h5555_6666_7777_8888);
    chk("simul_then_ifu", 64'(obs_g[$]), 64'd0);

    // Starvation guard: IFU waits while LSU keeps requesting
    ifu_arvalid = 1'b1; ifu_araddr = 64'h8000_0008;
    for (int i = 0; i < 5; i++) begin
      if (!lsu_arvalid) begin
        lsu_arvalid = 1'b1;
        lsu_araddr  = 64'h8000_2000 + 64'(i * 8);
      end
      txn(0, 0, 0, 64'(i + 100));
    end
    for (int i = 0; i < 5; i++) seq[4-i] = obs_g[obs_g.size() - 5 + i];
    chk("starve_seq", 64'(seq), 64'b11110);
    txn(0, 0, 0, 64'hdead);   // drain the LSU request left pending
    chk("after_starve_lsu", 64'(obs_g[$]), 64'd1);

    // Backpressure on every phase
    ifu_arvalid = 1'b1; ifu_araddr = 64'h8000_0100;
    txn(3, 5, 2, 64'hcafe_f00d_1234_5678);

    // Reset during LSU R wait
    lsu_arvalid = 1'b1; lsu_araddr = 64'h8000_3000;
    model_grant(w);
    tick();
    s_arready = 1'b1;
    tick();
    s_arready   = 1'b0;
    lsu_arvalid = 1'b0;
    lsu_rready  = 1'b1;
    #1 chk("mid_r_rready", 64'(s_rready), 64'd1);
    rst_n = 1'b0;
    #1 chk_idle("rst_mid_r");
    s_rvalid = 1'b1;
    s_rdata  = 64'h0bad_0bad;
    #1 chk("rst_r_ignored", 64'({s_rready, ifu_rvalid, lsu_rvalid}), 64'd0);
    tick();
    rst_n = 1'b1;
    m_cnt = 0;
    tick();
    chk("post_rst_ignored", 64'({s_rready, ifu_rvalid, lsu_rvalid, |lsu_rdata}), 64'd0);
    s_rvalid   = 1'b0;
    s_rdata    = '0;
    lsu_rready = 1'b0;
    #1 chk_idle("post_rst_idle");

    // Back-to-back IFU reads: IDLE bubble checked at the end of the first txn
    ifu_arvalid = 1'b1; ifu_araddr = 64'h8000_0000;
    txn(0, 0, 0, 64'h13);
    ifu_arvalid = 1'b1; ifu_araddr = 64'h8000_0004;
    txn(0, 0, 0, 64'h93);

    // Random traffic, LSU-biased so the starvation guard fires
    repeat (40) begin
      if (!ifu_arvalid && $urandom_range(0, 1) == 1) begin
        ifu_arvalid = 1'b1;
        ifu_araddr  = {$urandom, $urandom};
      end
      if (!lsu_arvalid && $urandom_range(0, 3) != 0) begin
        lsu_arvalid = 1'b1;
        lsu_araddr  = {$urandom, $urandom};
      end
      if (!ifu_arvalid && !lsu_arvalid) begin
        lsu_arvalid = 1'b1;
        lsu_araddr  = {$urandom, $urandom};
      end
      txn($urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 2), {$urandom, $urandom});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
